// File: rtl/enigma_rotor_stack_if.sv
// Letter stream and slot-configuration bus of the rotor stack.
// The slave side is the cipher engine; the master side is the keyboard/display logic.
interface enigma_rotor_stack_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_letter;
  logic       step_en;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_letter;
  logic       out_err;
  logic       cfg_we;
  logic [2:0] cfg_slot;
  logic [2:0] cfg_wheel;
  logic [4:0] cfg_ring;
  logic [4:0] cfg_pos;
  logic       cfg_err;

  modport master (
    output in_valid, in_letter, step_en, out_ready,
    output cfg_we, cfg_slot, cfg_wheel, cfg_ring, cfg_pos,
    input  in_ready, out_valid, out_letter, out_err, cfg_err
  );

  modport slave (
    input  in_valid, in_letter, step_en, out_ready,
    input  cfg_we, cfg_slot, cfg_wheel, cfg_ring, cfg_pos,
    output in_ready, out_valid, out_letter, out_err, cfg_err
  );
endinterface

// File: rtl/enigma_rotor_stack.sv
// Multi-rotor Enigma engine: selectable wheels I..V per slot, ring settings,
// double-step stepping and a fixed reflector. One stage per clock.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a letter; slot configuration writes accepted here
// STEP   | advance rotor windows (skipped for out-of-range letters)
// FWD    | pass through slot k, right to left (k = 0..N-1)
// REFL   | reflector
// BWD    | pass back through slot k, left to right (k = N-1..0)
// DONE   | hold result until the consumer takes it
module enigma_rotor_stack #(
  parameter int NUM_ROTORS = 3,
  parameter int REFLECTOR  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  enigma_rotor_stack_if.slave     bus,
  output logic [5*NUM_ROTORS-1:0] pos_out
);

  localparam logic [207:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [207:0] WIRE_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [207:0] WIRE_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [207:0] REFL_WIRE = (REFLECTOR == 1) ? "FVPJIAOYEDRZXWGCTKUQSBNMHL"
                                                        : "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [2:0] LAST = 3'(NUM_ROTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_FWD, S_REFL, S_BWD, S_DONE} state_t;

  // Wiring strings hold ASCII capitals, first character in the top byte.
  function automatic logic [4:0] rom_char(input logic [207:0] s, input logic [4:0] idx);
    return 5'(8'(s >> {5'd25 - idx, 3'b000}) - 8'd65);
  endfunction

  function automatic logic [4:0] wheel_map(input logic [2:0] wheel, input logic [4:0] idx);
    case (wheel)
      3'd0:    return rom_char(WIRE_I, idx);
      3'd1:    return rom_char(WIRE_II, idx);
      3'd2:    return rom_char(WIRE_III, idx);
      3'd3:    return rom_char(WIRE_IV, idx);
      default: return rom_char(WIRE_V, idx);
    endcase
  endfunction

  // Inverse wiring found by search so only the forward tables exist in source.
  function automatic logic [4:0] wheel_inv(input logic [2:0] wheel, input logic [4:0] c);
    logic [4:0] r;
    r = 5'd0;
    for (int j = 0; j < 26; j++)
      if (wheel_map(wheel, 5'(j)) == c) r = 5'(j);
    return r;
  endfunction

  function automatic logic [4:0] notch(input logic [2:0] wheel);
    case (wheel)
      3'd0:    return 5'd16;
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      default: return 5'd25;
    endcase
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = 6'(a) + 6'(b);
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    return (a >= b) ? (a - b) : 5'(6'(a) + 6'd26 - 6'(b));
  endfunction

  function automatic logic [4:0] through_slot(input logic [4:0] x, input logic [4:0] pos,
                                              input logic [4:0] ring, input logic [2:0] wheel,
                                              input logic inv);
    logic [4:0] t;
    logic [4:0] c;
    t = sub26(add26(x, pos), ring);
    c = inv ? wheel_inv(wheel, t) : wheel_map(wheel, t);
    return add26(sub26(c, pos), ring);
  endfunction

  state_t     state_q, state_n;
  logic [2:0] k_q, k_n;
  logic [4:0] x_q;
  logic       err_q;
  logic       step_q;
  logic       cfg_err_q;
  logic [4:0] pos_q   [NUM_ROTORS];
  logic [4:0] ring_q  [NUM_ROTORS];
  logic [2:0] wheel_q [NUM_ROTORS];

  logic                  accept;
  logic                  cfg_ok;
  logic [NUM_ROTORS-1:0] hit;
  logic [NUM_ROTORS-1:0] carry_in;
  logic [4:0]            pos_step [NUM_ROTORS];
  logic [4:0]            sel_pos;
  logic [4:0]            sel_ring;
  logic [2:0]            sel_wheel;
  logic [4:0]            x_stage;

  assign accept = bus.in_valid && (state_q == S_IDLE);
  assign cfg_ok = bus.cfg_we && (state_q == S_IDLE) && !accept &&
                  (int'(bus.cfg_slot) < NUM_ROTORS) && (bus.cfg_wheel < 3'd5) &&
                  (bus.cfg_ring < 5'd26) && (bus.cfg_pos < 5'd26);

  // FSM state and stage index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_n;
      k_q     <= k_n;
    end
  end

  // Next-state sequencing and handshake outputs.
  always_comb begin
    state_n       = state_q;
    k_n           = k_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_n = S_STEP;
      end
      S_STEP: begin
        k_n     = 3'd0;
        state_n = err_q ? S_DONE : S_FWD;
      end
      S_FWD: begin
        if (k_q == LAST) state_n = S_REFL;
        else             k_n     = k_q + 3'd1;
      end
      S_REFL: begin
        state_n = S_BWD;
        k_n     = LAST;
      end
      S_BWD: begin
        if (k_q == 3'd0) state_n = S_DONE;
        else             k_n     = k_q - 3'd1;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stepped positions from the pre-step windows; carry_in[i] means the slot to the right sits on its notch.
  always_comb begin
    for (int i = 0; i < NUM_ROTORS; i++)
      hit[i] = (pos_q[i] == notch(wheel_q[i]));
    carry_in = NUM_ROTORS'(hit << 1) | NUM_ROTORS'(1);
    for (int i = 0; i < NUM_ROTORS; i++)
      pos_step[i] = (carry_in[i] || (i > 0 && i < NUM_ROTORS - 1 && hit[i]))
                    ? add26(pos_q[i], 5'd1) : pos_q[i];
  end

  // Settings of the slot currently being traversed.
  always_comb begin
    sel_pos   = pos_q[0];
    sel_ring  = ring_q[0];
    sel_wheel = wheel_q[0];
    for (int i = 0; i < NUM_ROTORS; i++)
      if (k_q == 3'(i)) begin
        sel_pos   = pos_q[i];
        sel_ring  = ring_q[i];
        sel_wheel = wheel_q[i];
      end
  end

  // Letter after the current traversal stage.
  always_comb begin
    x_stage = x_q;
    case (state_q)
      S_FWD:   x_stage = through_slot(x_q, sel_pos, sel_ring, sel_wheel, 1'b0);
      S_REFL:  x_stage = rom_char(REFL_WIRE, x_q);
      S_BWD:   x_stage = through_slot(x_q, sel_pos, sel_ring, sel_wheel, 1'b1);
      default: x_stage = x_q;
    endcase
  end

  // Letter, slot configuration and stepping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= 5'd0;
      err_q     <= 1'b0;
      step_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        pos_q[i]   <= 5'd0;
        ring_q[i]  <= 5'd0;
        wheel_q[i] <= 3'((NUM_ROTORS - 1 - i) % 5);
      end
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_ok;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_q    <= bus.in_letter;
            err_q  <= (bus.in_letter >= 5'd26);
            step_q <= bus.step_en;
          end else if (cfg_ok) begin
            for (int i = 0; i < NUM_ROTORS; i++)
              if (bus.cfg_slot == 3'(i)) begin
                wheel_q[i] <= bus.cfg_wheel;
                ring_q[i]  <= bus.cfg_ring;
                pos_q[i]   <= bus.cfg_pos;
              end
          end
        end
        S_STEP: begin
          if (step_q && !err_q)
            for (int i = 0; i < NUM_ROTORS; i++) pos_q[i] <= pos_step[i];
        end
        S_FWD, S_REFL, S_BWD: x_q <= x_stage;
        default: ;
      endcase
    end
  end

  assign bus.out_letter = x_q;
  assign bus.out_err    = err_q;
  assign bus.cfg_err    = cfg_err_q;

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_pos
    assign pos_out[5*g +: 5] = pos_q[g];
  end

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Bench for enigma_rotor_stack: letter-level Enigma model plus literal vectors.
module tb_enigma_rotor_stack;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic [5*N-1:0] pos_out;
  always #5 clk = ~clk;

  enigma_rotor_stack_if bus ();

  enigma_rotor_stack #(.NUM_ROTORS(N), .REFLECTOR(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pos_out (pos_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- letter-level model ----------------
  string WIRES [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMJQOFECK"};
  string UKW = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int NOTCH [5] = '{16, 4, 21, 9, 25};
  int m_pos [N];
  int m_ring [N];
  int m_wheel [N];

  function automatic int mod26(input int v);
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic int wmap(input int w, input int i);
    string s;
    s = WIRES[w];
    return int'(s[i]) - 65;
  endfunction

  function automatic int winv(input int w, input int c);
    for (int j = 0; j < 26; j++)
      if (wmap(w, j) == c) return j;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pos[i] = 0;
      m_ring[i] = 0;
      m_wheel[i] = (N - 1 - i) % 5;
    end
  endfunction

  function automatic void model_step();
    int pre [N];
    bit adv;
    for (int i = 0; i < N; i++) pre[i] = m_pos[i];
    for (int i = 0; i < N; i++) begin
      adv = 0;
      if (i == 0) adv = 1;
      else begin
        if (pre[i-1] == NOTCH[m_wheel[i-1]]) adv = 1;
        if (i < N - 1 && pre[i] == NOTCH[m_wheel[i]]) adv = 1;
      end
      if (adv) m_pos[i] = (m_pos[i] + 1) % 26;
    end
  endfunction

  function automatic int model_cipher(input int letter);
    int x;
    x = letter;
    for (int k = 0; k < N; k++)
      x = mod26(wmap(m_wheel[k], mod26(x + m_pos[k] - m_ring[k])) - m_pos[k] + m_ring[k]);
    x = int'(UKW[x]) - 65;
    for (int k = N - 1; k >= 0; k--)
      x = mod26(winv(m_wheel[k], mod26(x + m_pos[k] - m_ring[k])) - m_pos[k] + m_ring[k]);
    return x;
  endfunction

  // ---------------- compare process ----------------
  bit armed = 0;
  int exp_letter = 0;
  int exp_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (!armed) check("unexpected_out_valid", bus.out_valid, 0);
        else begin
          check("out_letter", bus.out_letter, exp_letter);
          check("out_err", bus.out_err, exp_err);
        end
      end
      if (bus.in_ready)
        for (int i = 0; i < N; i++) check($sformatf("idle_pos%0d", i), pos_out[5*i +: 5], m_pos[i]);
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic cfg(input int slot, input int wheel, input int ring, input int pos, input bit exp_e);
    bus.cfg_slot = 3'(slot);
    bus.cfg_wheel = 3'(wheel);
    bus.cfg_ring = 5'(ring);
    bus.cfg_pos = 5'(pos);
    bus.cfg_we = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    check("cfg_err", bus.cfg_err, int'(exp_e));
    if (!exp_e) begin
      m_wheel[slot] = wheel;
      m_ring[slot] = ring;
      m_pos[slot] = pos;
    end
  endtask

  task automatic send(input int letter, input bit st, input bit hold, input bit cfg_mid, output int got);
    int cyc;
    int exp_lat;
    int first;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("in_ready_idle", bus.in_ready, 1);
    if (hold) bus.out_ready = 1'b0;
    bus.in_letter = 5'(letter);
    bus.step_en = st;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (letter < 26) begin
      if (st) model_step();
      exp_letter = model_cipher(letter);
      exp_err = 0;
      exp_lat = 2 * N + 2;
    end else begin
      exp_letter = letter;
      exp_err = 1;
      exp_lat = 1;
    end
    armed = 1;
    check("in_ready_busy", bus.in_ready, 0);
    @(posedge clk); #1;
    cyc = 1;
    for (int i = 0; i < N; i++) check($sformatf("stepped_pos%0d", i), pos_out[5*i +: 5], m_pos[i]);
    if (cfg_mid) begin
      bus.cfg_slot = 3'd0; bus.cfg_wheel = 3'd0; bus.cfg_ring = 5'd5; bus.cfg_pos = 5'd7;
      bus.cfg_we = 1'b1;
      @(posedge clk); #1;
      cyc++;
      bus.cfg_we = 1'b0;
      check("cfg_err_busy", bus.cfg_err, 1);
      for (int i = 0; i < N; i++) check($sformatf("busy_cfg_pos%0d", i), pos_out[5*i +: 5], m_pos[i]);
    end
    while (!bus.out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("latency", cyc, exp_lat);
    got = bus.out_letter;
    if (hold) begin
      first = bus.out_letter;
      repeat (10) begin
        @(posedge clk); #1;
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_out_letter", bus.out_letter, first);
        check("hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    armed = 0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_return", bus.in_ready, 1);
  endtask

  task automatic send_word(input string plain, input string cipher);
    int got;
    for (int i = 0; i < plain.len(); i++) begin
      send(int'(plain[i]) - 65, 1'b1, 1'b0, 1'b0, got);
      check($sformatf("literal_%s_%0d", plain, i), got, int'(cipher[i]) - 65);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int got;
    bus.in_valid = 1'b0; bus.in_letter = 5'd0; bus.step_en = 1'b1; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_slot = 3'd0; bus.cfg_wheel = 3'd0; bus.cfg_ring = 5'd0; bus.cfg_pos = 5'd0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_letter", bus.out_letter, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_pos_out", pos_out, 0);

    send_word("AAAAA", "BDZGO");
    check("pos_after_aaaaa", pos_out, 5);

    cfg(2, 0, 0, 0, 0);
    cfg(1, 1, 0, 3, 0);
    cfg(0, 2, 0, 20, 0);
    send(0, 1'b1, 1'b0, 1'b0, got);
    check("double_step_ADV", pos_out, (0 << 10) | (3 << 5) | 21);
    send(0, 1'b1, 1'b0, 1'b0, got);
    check("double_step_AEW", pos_out, (0 << 10) | (4 << 5) | 22);
    send(0, 1'b1, 1'b0, 1'b0, got);
    check("double_step_BFX", pos_out, (1 << 10) | (5 << 5) | 23);

    for (int i = 0; i < N; i++) cfg(i, N - 1 - i, 1, 0, 0);
    send_word("AAAAA", "EWTYX");

    for (int i = 0; i < N; i++) cfg(i, N - 1 - i, 0, 0, 0);
    send_word("BDZGO", "AAAAA");

    send(4, 1'b1, 1'b1, 1'b0, got);
    send(11, 1'b1, 1'b0, 1'b1, got);
    send(7, 1'b0, 1'b0, 1'b0, got);
    send(25, 1'b1, 1'b0, 1'b0, got);

    cfg(0, 5, 0, 0, 1);
    cfg(3, 0, 0, 0, 1);
    cfg(0, 0, 26, 0, 1);
    cfg(0, 0, 0, 26, 1);

    send(30, 1'b1, 1'b0, 1'b0, got);
    check("range_err_letter", got, 30);

    // Abort a letter in flight with reset while it is in the forward pass.
    bus.in_letter = 5'd0; bus.step_en = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_pos_out", pos_out, 0);
    repeat (12) @(posedge clk);
    #1;
    send_word("AA", "BD");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
